// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the CPU controller and alu_seq.
//   master (controller): drives start, ALUConf, Sign, In1, In2;
//                        observes busy, done, Result, ResultHi, Zero, DivZero.
//   slave  (alu_seq)   : the mirror image.
// WIDTH must match the WIDTH of the alu_seq instance it is bound to.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       ALUConf;
  logic             Sign;
  logic [WIDTH-1:0] In1;
  logic [WIDTH-1:0] In2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] ResultHi;
  logic             Zero;
  logic             DivZero;

  modport master (
    output start, ALUConf, Sign, In1, In2,
    input  busy, done, Result, ResultHi, Zero, DivZero
  );

  modport slave (
    input  start, ALUConf, Sign, In1, In2,
    output busy, done, Result, ResultHi, Zero, DivZero
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU for the multi-cycle CPU.
//   Simple ops (ADD/OR/AND/SUB/SLT/NOR/XOR/ANDN/SRL/SRA/SLL) finish in 2 cycles,
//   shift-add MUL and restoring DIV finish in WIDTH+2 cycles (DIV by zero in 2).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   bus   - alu_seq_if.slave: start/ALUConf/Sign/In1/In2 in,
//           busy/done/Result/ResultHi/Zero/DivZero out (all outputs registered)
// Build option:
//   ALU_SEQ_DIV_EN - when defined, builds the divider for ALUConf 10101;
//                    otherwise 10101 behaves as an unlisted code.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);

  localparam int CW = SHW + 1;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_NOR  = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_SRL  = 5'b10000;
  localparam logic [4:0] OP_MUL  = 5'b10100;
  localparam logic [4:0] OP_SRA  = 5'b11000;
  localparam logic [4:0] OP_SLL  = 5'b11001;
  localparam logic [4:0] OP_ANDN = 5'b11010;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'b10101;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  // mcand: multiplicand magnitude (MUL) or divisor magnitude (DIV)
  logic [WIDTH-1:0] mcand_q, mcand_d;
  // hi/lo: running partial product (MUL) or remainder/quotient (DIV)
  logic [WIDTH:0]   hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_res_q, neg_res_d;
`ifdef ALU_SEQ_DIV_EN
  logic             neg_rem_q, neg_rem_d;
`endif
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             div_zero_q, div_zero_d;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.Result   = result_q;
  assign bus.ResultHi = result_hi_q;
  assign bus.Zero     = zero_q;
  assign bus.DivZero  = div_zero_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sg);
    return (sg && v[WIDTH-1]) ? ('0 - v) : v;
  endfunction

  // Single-cycle result for the simple ops, from the latched operands.
  logic [WIDTH-1:0] simple_res;
  logic [SHW-1:0]   sh;
  logic             lt;

  always_comb begin
    simple_res = '0;
    sh         = a_q[SHW-1:0];
    lt         = sign_q ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
    case (op_q)
      OP_ADD:  simple_res = a_q + b_q;
      OP_OR:   simple_res = a_q | b_q;
      OP_AND:  simple_res = a_q & b_q;
      OP_SUB:  simple_res = a_q - b_q;
      OP_SLT:  simple_res[0] = lt;
      OP_NOR:  simple_res = ~(a_q | b_q);
      OP_XOR:  simple_res = a_q ^ b_q;
      OP_SRL:  simple_res = b_q >> sh;
      OP_SRA:  simple_res = $signed(b_q) >>> sh;
      OP_SLL:  simple_res = b_q << sh;
      OP_ANDN: simple_res = a_q & ~b_q;
      default: simple_res = '0;
    endcase
  end

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sign_d      = sign_q;
    a_d         = a_q;
    b_d         = b_q;
    mcand_d     = mcand_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cnt_d       = cnt_q;
    neg_res_d   = neg_res_q;
`ifdef ALU_SEQ_DIV_EN
    neg_rem_d   = neg_rem_q;
`endif
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    div_zero_d  = div_zero_q;

    // Shift-add step: add multiplicand when the multiplier LSB is set, then
    // shift the {hi, lo} pair right; lo drains the multiplier as it fills.
    mul_sum = hi_q + (lo_q[0] ? {1'b0, mcand_q} : '0);
    prod    = {hi_q[WIDTH-1:0], lo_q};
    if (neg_res_q) prod = '0 - prod;
`ifdef ALU_SEQ_DIV_EN
    // Restoring step: shift the next dividend bit into the remainder and keep
    // the difference only if it did not go negative.
    div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    quo_fix   = neg_res_q ? ('0 - lo_q) : lo_q;
    rem_fix   = neg_rem_q ? ('0 - hi_q[WIDTH-1:0]) : hi_q[WIDTH-1:0];
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d      = bus.ALUConf;
          sign_d    = bus.Sign;
          a_d       = bus.In1;
          b_d       = bus.In2;
          cnt_d     = '0;
          busy_d    = 1'b1;
          neg_res_d = bus.Sign & (bus.In1[WIDTH-1] ^ bus.In2[WIDTH-1]);
`ifdef ALU_SEQ_DIV_EN
          neg_rem_d = bus.Sign & bus.In1[WIDTH-1];
`endif
          hi_d      = '0;
          if (bus.ALUConf == OP_MUL) begin
            state_d = S_MUL;
            mcand_d = mag(bus.In1, bus.Sign);
            lo_d    = mag(bus.In2, bus.Sign);
`ifdef ALU_SEQ_DIV_EN
          end else if (bus.ALUConf == OP_DIV) begin
            state_d = S_DIV;
            mcand_d = mag(bus.In2, bus.Sign);
            lo_d    = mag(bus.In1, bus.Sign);
`endif
          end else begin
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        result_d    = simple_res;
        result_hi_d = '0;
        zero_d      = (simple_res == '0);
        div_zero_d  = 1'b0;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_DONE;
      end

      // Counts 0..WIDTH-1 doing one step each, then spends count WIDTH on the
      // sign fix-up and output load, giving the WIDTH+2 start-to-done latency.
      S_MUL: begin
        if (cnt_q != CW'(WIDTH)) begin
          hi_d  = {1'b0, mul_sum[WIDTH:1]};
          lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
        end else begin
          result_d    = prod[WIDTH-1:0];
          result_hi_d = prod[2*WIDTH-1:WIDTH];
          zero_d      = (prod[WIDTH-1:0] == '0);
          div_zero_d  = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_DONE;
        end
      end

`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        if (b_q == '0) begin
          result_d    = '1;
          result_hi_d = a_q;
          zero_d      = 1'b0;
          div_zero_d  = 1'b1;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_DONE;
        end else if (cnt_q != CW'(WIDTH)) begin
          if (!div_diff[WIDTH]) begin
            hi_d = div_diff;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_shift;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          result_d    = quo_fix;
          result_hi_d = rem_fix;
          zero_d      = (quo_fix == '0);
          div_zero_d  = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_DONE;
        end
      end
`endif

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      sign_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      mcand_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      neg_res_q   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      neg_rem_q   <= 1'b0;
`endif
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      sign_q      <= sign_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mcand_q     <= mcand_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      neg_res_q   <= neg_res_d;
`ifdef ALU_SEQ_DIV_EN
      neg_rem_q   <= neg_rem_d;
`endif
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      div_zero_q  <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq at WIDTH=32.
// Expected results come from an arithmetic reference model (64-bit products,
// native signed division) and from hand-computed directed values.
module tb_alu_seq;

  localparam int W = 32;

  localparam logic [4:0] C_ADD  = 5'b00000;
  localparam logic [4:0] C_OR   = 5'b00001;
  localparam logic [4:0] C_AND  = 5'b00010;
  localparam logic [4:0] C_SUB  = 5'b00110;
  localparam logic [4:0] C_SLT  = 5'b00111;
  localparam logic [4:0] C_NOR  = 5'b01100;
  localparam logic [4:0] C_XOR  = 5'b01101;
  localparam logic [4:0] C_SRL  = 5'b10000;
  localparam logic [4:0] C_MUL  = 5'b10100;
  localparam logic [4:0] C_DIV  = 5'b10101;
  localparam logic [4:0] C_SRA  = 5'b11000;
  localparam logic [4:0] C_SLL  = 5'b11001;
  localparam logic [4:0] C_ANDN = 5'b11010;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
    $fatal(1, "watchdog");
  end

  logic [4:0] op_tab [0:13] = '{C_ADD, C_OR, C_AND, C_SUB, C_SLT, C_NOR, C_XOR,
                                C_SRL, C_MUL, C_DIV, C_SRA, C_SLL, C_ANDN, 5'b00011};

  // Reference model: result, high half, divide-by-zero flag and start-to-done latency.
  function automatic void ref_model(input logic [4:0] c, input logic sg,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [31:0] h,
                                    output logic dz, output int lat);
    logic [63:0] p;
    longint      sa, sb, q, rm;
    int          sh;
    sh  = int'(a[4:0]);
    r   = '0;
    h   = '0;
    dz  = 1'b0;
    lat = 2;
    case (c)
      C_ADD:  r = a + b;
      C_OR:   r = a | b;
      C_AND:  r = a & b;
      C_SUB:  r = a - b;
      C_SLT:  r = (sg ? (int'(a) < int'(b)) : (a < b)) ? 32'd1 : 32'd0;
      C_NOR:  r = ~(a | b);
      C_XOR:  r = a ^ b;
      C_ANDN: r = a & ~b;
      C_SRL:  r = b >> sh;
      C_SLL:  r = b << sh;
      C_SRA:  r = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      C_MUL: begin
        if (sg) begin
          sa = longint'(int'(a));
          sb = longint'(int'(b));
          p  = 64'(sa * sb);
        end else begin
          p = {32'h0, a} * {32'h0, b};
        end
        r   = p[31:0];
        h   = p[63:32];
        lat = W + 2;
      end
`ifdef ALU_SEQ_DIV_EN
      C_DIV: begin
        if (b == 32'h0) begin
          r  = 32'hFFFF_FFFF;
          h  = a;
          dz = 1'b1;
        end else begin
          lat = W + 2;
          if (sg) begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
          end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
          end
          q  = sa / sb;
          rm = sa % sb;
          r  = q[31:0];
          h  = rm[31:0];
        end
      end
`endif
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Issues one operation and waits (bounded) for done; operands are scrambled
  // right after acceptance.
  task automatic run_op(input logic [4:0] conf, input logic sg,
                        input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output logic busy_at_done,
                        output logic [31:0] res, output logic [31:0] hi,
                        output logic z, output logic dz,
                        output logic dn_after, output logic [31:0] res_after);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.ALUConf = conf;
    bus.Sign    = sg;
    bus.In1     = a;
    bus.In2     = b;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.ALUConf = 5'($urandom);
    bus.Sign    = 1'($urandom);
    bus.In1     = $urandom;
    bus.In2     = $urandom;
    lat      = 1;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 80) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    busy_at_done = bus.busy;
    res = bus.Result;
    hi  = bus.ResultHi;
    z   = bus.Zero;
    dz  = bus.DivZero;
    @(negedge clk);
    dn_after  = bus.done;
    res_after = bus.Result;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.ALUConf = '0; bus.Sign = 1'b0; bus.In1 = '0; bus.In2 = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
    checks++;
    if (bus.Result !== 32'h0 || bus.ResultHi !== 32'h0) begin
      errors++;
      $display("FAIL reset_results: Result=%h ResultHi=%h required 0 0", bus.Result, bus.ResultHi);
    end
    checks++;
    if (bus.Zero !== 1'b0 || bus.DivZero !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: Zero=%b DivZero=%b required 0 0", bus.Zero, bus.DivZero);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed();
    logic [4:0]  c_tab  [0:6] = '{C_SUB, C_SRA, C_SLL, C_MUL, C_MUL, C_DIV, C_DIV};
    logic        s_tab  [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] a_tab  [0:6] = '{32'd5, 32'd4, 32'd33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd9};
    logic [31:0] b_tab  [0:6] = '{32'd5, 32'h8000_0000, 32'd1, 32'd7, 32'd2, 32'd2, 32'd0};
`ifdef ALU_SEQ_DIV_EN
    logic [31:0] er_tab [0:6] = '{32'h0, 32'hF800_0000, 32'd2, 32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] eh_tab [0:6] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'd9};
    logic        ed_tab [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          el_tab [0:6] = '{2, 2, 2, 34, 34, 34, 2};
`else
    logic [31:0] er_tab [0:6] = '{32'h0, 32'hF800_0000, 32'd2, 32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'h0};
    logic [31:0] eh_tab [0:6] = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0};
    logic        ed_tab [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          el_tab [0:6] = '{2, 2, 2, 34, 34, 2, 2};
`endif
    int lat, bc;
    logic bd, z, dz, dn;
    logic [31:0] r, h, ra;
    for (int i = 0; i < 7; i++) begin
      run_op(c_tab[i], s_tab[i], a_tab[i], b_tab[i], lat, bc, bd, r, h, z, dz, dn, ra);
      checks++;
      if (lat !== el_tab[i]) begin
        errors++;
        $display("FAIL directed%0d_latency: got %0d required %0d", i, lat, el_tab[i]);
      end
      checks++;
      if (r !== er_tab[i] || h !== eh_tab[i]) begin
        errors++;
        $display("FAIL directed%0d_result: got %h_%h required %h_%h", i, h, r, eh_tab[i], er_tab[i]);
      end
      checks++;
      if (z !== (er_tab[i] == 32'h0) || dz !== ed_tab[i]) begin
        errors++;
        $display("FAIL directed%0d_flags: Zero=%b DivZero=%b required %b %b",
                 i, z, dz, (er_tab[i] == 32'h0), ed_tab[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat, bc, elat;
    logic bd, z, dz, dn, sg, edz;
    logic [31:0] a, b, r, h, ra, er, eh;
    logic [4:0] c;
    for (int n = 0; n < 60; n++) begin
      c  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : op_tab[$urandom_range(0, 13)];
      sg = 1'($urandom);
      a  = pick_operand();
      b  = pick_operand();
      if ($urandom_range(0, 7) == 0) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      ref_model(c, sg, a, b, er, eh, edz, elat);
      run_op(c, sg, a, b, lat, bc, bd, r, h, z, dz, dn, ra);
      checks++;
      if (r !== er || h !== eh) begin
        errors++;
        $display("FAIL random_result op=%b sg=%b a=%h b=%h: got %h_%h required %h_%h",
                 c, sg, a, b, h, r, eh, er);
      end
      checks++;
      if (z !== (er == 32'h0) || dz !== edz) begin
        errors++;
        $display("FAIL random_flags op=%b a=%h b=%h: Zero=%b DivZero=%b required %b %b",
                 c, a, b, z, dz, (er == 32'h0), edz);
      end
      checks++;
      if (lat !== elat || bc !== elat - 1 || bd !== 1'b0) begin
        errors++;
        $display("FAIL random_timing op=%b: latency=%0d busy_cycles=%0d busy_at_done=%b required %0d %0d 0",
                 c, lat, bc, bd, elat, elat - 1);
      end
      checks++;
      if (dn !== 1'b0 || ra !== er) begin
        errors++;
        $display("FAIL random_pulse_hold op=%b: done_after=%b Result_after=%h required 0 %h",
                 c, dn, ra, er);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, er, eh;
    logic edz;
    int elat, dones, busy_cnt, first_done;
    a = $urandom;
    b = $urandom;
    ref_model(C_MUL, 1'b1, a, b, er, eh, edz, elat);
    dones = 0; busy_cnt = 0; first_done = -1;
    @(negedge clk);
    bus.start = 1'b1; bus.ALUConf = C_MUL; bus.Sign = 1'b1; bus.In1 = a; bus.In2 = b;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = k;
      end
      if (k == 34) begin
        bus.start = 1'b0;
      end else begin
        bus.In1 = $urandom;
        bus.In2 = $urandom;
      end
    end
    checks++;
    if (dones !== 1 || first_done !== elat) begin
      errors++;
      $display("FAIL b2b_single_done: dones=%0d at=%0d required 1 at %0d", dones, first_done, elat);
    end
    checks++;
    if (busy_cnt !== 33) begin
      errors++;
      $display("FAIL b2b_busy_cycles: got %0d required 33", busy_cnt);
    end
    checks++;
    if (bus.Result !== er || bus.ResultHi !== eh) begin
      errors++;
      $display("FAIL b2b_result: got %h_%h required %h_%h", bus.ResultHi, bus.Result, eh, er);
    end
    // The cycle right after done is IDLE: a start there must be taken.
    @(negedge clk);
    bus.start = 1'b1; bus.ALUConf = C_ADD; bus.In1 = 32'd1; bus.In2 = 32'd2;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.Result !== 32'd3) begin
      errors++;
      $display("FAIL b2b_restart: done=%b Result=%h required 1 00000003", bus.done, bus.Result);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, dones;
    logic bd, z, dz, dn;
    logic [31:0] r, h, ra;
    logic [4:0] c;
`ifdef ALU_SEQ_DIV_EN
    c = C_DIV;
`else
    c = C_MUL;
`endif
    run_op(C_OR, 1'b0, 32'hF0, 32'h0F, lat, bc, bd, r, h, z, dz, dn, ra);
    checks++;
    if (r !== 32'hFF) begin
      errors++;
      $display("FAIL pre_reset_or: got %h required 000000ff", r);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.ALUConf = c; bus.Sign = 1'b0; bus.In1 = 32'd100; bus.In2 = 32'd3;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Result !== 32'h0 ||
        bus.ResultHi !== 32'h0 || bus.Zero !== 1'b0 || bus.DivZero !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: busy=%b done=%b Result=%h ResultHi=%h Zero=%b DivZero=%b required all 0",
               bus.busy, bus.done, bus.Result, bus.ResultHi, bus.Zero, bus.DivZero);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: busy/done cycles=%0d required 0", dones);
    end
    run_op(C_ADD, 1'b0, 32'd1, 32'd2, lat, bc, bd, r, h, z, dz, dn, ra);
    checks++;
    if (r !== 32'd3 || h !== 32'h0 || lat !== 2) begin
      errors++;
      $display("FAIL post_reset_add: Result=%h ResultHi=%h latency=%0d required 00000003 0 2", r, h, lat);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
